// File: rtl/core_stim_ctrl.sv
// Stimulus controller for a core under test: periodic stall generator,
// LFSR-timed interrupt requests while the core idles, and an end-of-run
// detector (FINISH opcode, PC-stack overflow, watchdog timeout).
module core_stim_ctrl #(
   parameter int          PMD_SIZE  = 32,
   parameter int          TMO_W     = 10,
   parameter int          STALL_HI  = 1,
   parameter int          STALL_LO  = 2,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ps_idle,
   input  logic [PMD_SIZE-1:0] pm_ps_op,
   input  logic                pcstck_ovf,
   output logic                interrupt,
   output logic                stallb_en,
   output logic                done,
   output logic [1:0]          done_code,
   output logic [TMO_W-1:0]    tmo_cnt
);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FIRE  = 2'd2
   } irq_state_e;

   localparam logic [7:0] SEED    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [3:0] HI_LAST = 4'(STALL_HI - 1);
   localparam logic [3:0] LO_LAST = 4'(STALL_LO - 1);

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_FINISH  = 2'b01;
   localparam logic [1:0] CODE_OVF     = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT = 2'b11;

   irq_state_e       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             irq_q, irq_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic             stall_hi_q, stall_hi_d;
   logic [3:0]       stall_cnt_q, stall_cnt_d;
   logic             done_q, done_d;
   logic [1:0]       code_q, code_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic             finish;
   logic             timeout;
   logic             op_unused;

   assign finish    = (pm_ps_op[PMD_SIZE-1 -: 10] == 10'b00_0000_0001);
   assign timeout   = (tmo_q == '1);
   assign op_unused = ^pm_ps_op[PMD_SIZE-11:0];

   // End-of-run detection with cause priority, plus the saturating watchdog.
   always_comb begin
      done_d = done_q;
      code_d = code_q;
      tmo_d  = tmo_q;
      if (!done_q) begin
         if (finish) begin
            done_d = 1'b1;
            code_d = CODE_FINISH;
         end else if (pcstck_ovf) begin
            done_d = 1'b1;
            code_d = CODE_OVF;
         end else if (timeout) begin
            done_d = 1'b1;
            code_d = CODE_TIMEOUT;
         end else begin
            code_d = CODE_NONE;
         end
         if (!timeout) begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1, frozen once the run has ended.
   always_comb begin
      lfsr_d = lfsr_q;
      if (!done_q) begin
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   // Stall phase generator; parked in the high phase once done.
   always_comb begin
      stall_hi_d  = stall_hi_q;
      stall_cnt_d = stall_cnt_q;
      if (done_d) begin
         stall_hi_d  = 1'b1;
         stall_cnt_d = '0;
      end else if (stall_hi_q) begin
         if (stall_cnt_q == HI_LAST) begin
            stall_cnt_d = '0;
            if (STALL_LO != 0) begin
               stall_hi_d = 1'b0;
            end
         end else begin
            stall_cnt_d = stall_cnt_q + 4'd1;
         end
      end else begin
         if (stall_cnt_q == LO_LAST) begin
            stall_hi_d  = 1'b1;
            stall_cnt_d = '0;
         end else begin
            stall_cnt_d = stall_cnt_q + 4'd1;
         end
      end
   end

   // Interrupt FSM next state. The countdown fires on the edge that would take
   // cnt from 1 to 0, so a loaded value L yields a pulse L edges after loading
   // (L = 0 fires straight from WAIT) and pulse spacing is L+2 while idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_WAIT: begin
            if (ps_idle) begin
               if (lfsr_q[2:0] == 3'd0) begin
                  state_d = ST_FIRE;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_COUNT;
                  cnt_d   = lfsr_q[2:0];
               end
            end
         end
         ST_COUNT: begin
            if (!ps_idle) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else if (cnt_q <= 3'd1) begin
               state_d = ST_FIRE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_FIRE: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
      endcase
      if (done_d) begin
         state_d = ST_WAIT;
         cnt_d   = '0;
      end
      irq_d = (state_d == ST_FIRE);
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_WAIT;
         cnt_q       <= '0;
         irq_q       <= 1'b0;
         lfsr_q      <= SEED;
         stall_hi_q  <= 1'b1;
         stall_cnt_q <= '0;
         done_q      <= 1'b0;
         code_q      <= CODE_NONE;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         irq_q       <= irq_d;
         lfsr_q      <= lfsr_d;
         stall_hi_q  <= stall_hi_d;
         stall_cnt_q <= stall_cnt_d;
         done_q      <= done_d;
         code_q      <= code_d;
         tmo_q       <= tmo_d;
      end
   end

   assign interrupt = irq_q;
   assign stallb_en = stall_hi_q;
   assign done      = done_q;
   assign done_code = code_q;
   assign tmo_cnt   = tmo_q;

endmodule

// File: tb/tb_core_stim_ctrl.sv
// Self-checking bench for core_stim_ctrl: expected interrupt edges and stall
// levels are queued from an independent LFSR/timing model and popped as the
// DUT output is sampled on the falling clock edge.
module tb_core_stim_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps_idle;
   logic [31:0] pm_ps_op;
   logic        pcstck_ovf;
   logic        interrupt;
   logic        stallb_en;
   logic        done;
   logic [1:0]  done_code;
   logic [9:0]  tmo_cnt;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;
   int exp_q[$];
   logic stall_q[$];

   always #5 clk = ~clk;

   core_stim_ctrl #(
      .PMD_SIZE (32),
      .TMO_W    (10),
      .STALL_HI (1),
      .STALL_LO (2),
      .LFSR_SEED(8'hA5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps_idle   (ps_idle),
      .pm_ps_op  (pm_ps_op),
      .pcstck_ovf(pcstck_ovf),
      .interrupt (interrupt),
      .stallb_en (stallb_en),
      .done      (done),
      .done_code (done_code),
      .tmo_cnt   (tmo_cnt)
   );

   // LFSR value after k shifts from the seed.
   function automatic logic [7:0] lfsr_at(input int k);
      logic [7:0] l;
      l = 8'hA5;
      for (int i = 0; i < k; i++) begin
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      return l;
   endfunction

   // Queue the edges at which pulses occur when ps_idle is held from edge e.
   task automatic predict_fires(input int e, input int last);
      int f;
      logic [7:0] v;
      forever begin
         v = lfsr_at(e - 1);
         f = e + int'(v[2:0]);
         if (f > last) break;
         exp_q.push_back(f);
         e = f + 2;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      edge_n++;
      @(negedge clk);
   endtask

   task automatic apply_reset;
      @(negedge clk);
      reset      = 1'b0;
      ps_idle    = 1'b0;
      pm_ps_op   = '0;
      pcstck_ovf = 1'b0;
      exp_q.delete();
      stall_q.delete();
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      edge_n = 0;
   endtask

   task automatic test_reset;
      reset      = 1'b0;
      ps_idle    = 1'b0;
      pm_ps_op   = '0;
      pcstck_ovf = 1'b0;
      #12;
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", interrupt); end
      checks++; if (stallb_en !== 1'b1) begin errors++; $display("FAIL rst_stall got %b want 1", stallb_en); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (done_code !== 2'b00) begin errors++; $display("FAIL rst_code got %b want 00", done_code); end
      checks++; if (tmo_cnt !== 10'd0) begin errors++; $display("FAIL rst_tmo got %0d want 0", tmo_cnt); end
   endtask

   task automatic test_stall;
      logic exp_s;
      apply_reset();
      checks++; if (stallb_en !== 1'b1) begin errors++; $display("FAIL stall_c0 got %b want 1", stallb_en); end
      for (int n = 1; n <= 12; n++) begin
         stall_q.push_back((n % 3) == 0);
         tick();
         exp_s = stall_q.pop_front();
         checks++; if (stallb_en !== exp_s) begin errors++; $display("FAIL stall_e%0d got %b want %b", n, stallb_en, exp_s); end
         checks++; if (tmo_cnt !== 10'(n)) begin errors++; $display("FAIL tmo_e%0d got %0d want %0d", n, tmo_cnt, n); end
         checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL stall_irq_e%0d got %b want 0", n, interrupt); end
      end
   endtask

   task automatic test_interrupt;
      int exp_f;
      apply_reset();
      predict_fires(5, 200);
      for (int n = 1; n <= 200; n++) begin
         ps_idle = (n >= 5);
         tick();
         if (interrupt !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL irq_extra got pulse at edge %0d want none", n);
            end else begin
               exp_f = exp_q.pop_front();
               if (n !== exp_f) begin errors++; $display("FAIL irq_edge got %0d want %0d", n, exp_f); end
            end
         end
      end
      ps_idle = 1'b0;
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL irq_missing got %0d unseen want 0", exp_q.size()); end
   endtask

   task automatic test_abort;
      int e, l, d, r, f, k, exp_f;
      logic [7:0] v;
      e = 0; l = 0;
      for (k = 2; k < 100; k++) begin
         v = lfsr_at(k);
         if (v[2:0] >= 3'd3) begin
            e = k + 1;
            l = int'(v[2:0]);
            break;
         end
      end
      checks++; if (e == 0) begin errors++; $display("FAIL abort_setup got none want load>=3"); end
      if (e != 0) begin
         apply_reset();
         d = e + l - 2;
         r = d + 3;
         v = lfsr_at(r - 1);
         f = r + int'(v[2:0]);
         exp_q.push_back(f);
         for (int n = 1; n <= f + 1; n++) begin
            ps_idle = (n >= e && n < d) || (n >= r);
            tick();
            if (interrupt !== 1'b0) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++; $display("FAIL abort_extra got pulse at edge %0d want none", n);
               end else begin
                  exp_f = exp_q.pop_front();
                  if (n !== exp_f) begin errors++; $display("FAIL abort_edge got %0d want %0d", n, exp_f); end
               end
            end
         end
         ps_idle = 1'b0;
         checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing got %0d unseen want 0", exp_q.size()); end
      end
   endtask

   task automatic test_finish;
      logic [9:0] t;
      apply_reset();
      repeat (3) tick();
      pm_ps_op = 32'h0080_0000;
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL nofin_done got %b want 0", done); end
      checks++; if (done_code !== 2'b00) begin errors++; $display("FAIL nofin_code got %b want 00", done_code); end
      pm_ps_op   = 32'h0040_0000;
      pcstck_ovf = 1'b1;
      ps_idle    = 1'b1;
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL fin_done got %b want 1", done); end
      checks++; if (done_code !== 2'b01) begin errors++; $display("FAIL fin_code got %b want 01", done_code); end
      t = tmo_cnt;
      pm_ps_op   = '0;
      pcstck_ovf = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick();
         checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL fin_irq got %b want 0", interrupt); end
         checks++; if (stallb_en !== 1'b1) begin errors++; $display("FAIL fin_stall got %b want 1", stallb_en); end
         checks++; if (done_code !== 2'b01) begin errors++; $display("FAIL fin_hold got %b want 01", done_code); end
         checks++; if (tmo_cnt !== t) begin errors++; $display("FAIL fin_tmo got %0d want %0d", tmo_cnt, t); end
      end
      ps_idle = 1'b0;
      apply_reset();
      repeat (2) tick();
      pcstck_ovf = 1'b1;
      tick();
      pcstck_ovf = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done got %b want 1", done); end
      checks++; if (done_code !== 2'b10) begin errors++; $display("FAIL ovf_code got %b want 10", done_code); end
   endtask

   task automatic test_timeout;
      bit ok;
      apply_reset();
      ok = 1'b1;
      for (int n = 1; n <= 1023; n++) begin
         tick();
         if (done !== 1'b0 || tmo_cnt !== 10'(n)) ok = 1'b0;
      end
      checks++; if (!ok) begin errors++; $display("FAIL tmo_ramp got early done/bad count want clean ramp"); end
      checks++; if (tmo_cnt !== 10'h3FF) begin errors++; $display("FAIL tmo_full got %h want 3ff", tmo_cnt); end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done got %b want 1", done); end
      checks++; if (done_code !== 2'b11) begin errors++; $display("FAIL tmo_code got %b want 11", done_code); end
      repeat (5) tick();
      checks++; if (tmo_cnt !== 10'h3FF) begin errors++; $display("FAIL tmo_hold got %h want 3ff", tmo_cnt); end
      checks++; if (done_code !== 2'b11) begin errors++; $display("FAIL tmo_code_hold got %b want 11", done_code); end
   endtask

   task automatic test_async_reset;
      int exp_f;
      logic exp_s;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %b want 0", done); end
      checks++; if (done_code !== 2'b00) begin errors++; $display("FAIL arst_code got %b want 00", done_code); end
      checks++; if (tmo_cnt !== 10'd0) begin errors++; $display("FAIL arst_tmo got %0d want 0", tmo_cnt); end
      checks++; if (stallb_en !== 1'b1) begin errors++; $display("FAIL arst_stall got %b want 1", stallb_en); end
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL arst_irq got %b want 0", interrupt); end
      #1 reset = 1'b1;
      edge_n = 0;
      exp_q.delete();
      stall_q.delete();
      @(negedge clk);
      predict_fires(1, 12);
      for (int n = 1; n <= 12; n++) begin
         ps_idle = 1'b1;
         stall_q.push_back((n % 3) == 0);
         tick();
         exp_s = stall_q.pop_front();
         checks++; if (stallb_en !== exp_s) begin errors++; $display("FAIL arst_stall_e%0d got %b want %b", n, stallb_en, exp_s); end
         if (interrupt !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL arst_irq_extra got pulse at edge %0d want none", n);
            end else begin
               exp_f = exp_q.pop_front();
               if (n !== exp_f) begin errors++; $display("FAIL arst_irq_edge got %0d want %0d", n, exp_f); end
            end
         end
      end
      ps_idle = 1'b0;
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL arst_missing got %0d unseen want 0", exp_q.size()); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done_after got %b want 0", done); end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_interrupt();
      test_abort();
      test_finish();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_stim_ctrl.md
CORE_STIM_CTRL -- requirements
Module: core_stim_ctrl

Interface
REQ-001 Parameter PMD_SIZE, default 32: width of the program-memory instruction word observed.
REQ-002 Parameter TMO_W, default 10: width of the watchdog timeout counter.
REQ-003 Parameter STALL_HI, default 1: cycles stallb_en is held high per stall period (1..15).
REQ-004 Parameter STALL_LO, default 2: cycles stallb_en is held low per stall period (0..15; 0 = never stall).
REQ-005 Parameter LFSR_SEED, default 8'hA5: initial LFSR value; 8'h00 is replaced by 8'h01.
REQ-006 clk  input  1  single core clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; low forces all state to reset values immediately.
REQ-008 ps_idle  input  1  program sequencer reports core is in IDLE.
REQ-009 pm_ps_op  input  PMD_SIZE  instruction word currently presented by program memory to the sequencer.
REQ-010 pcstck_ovf  input  1  PC-stack overflow sticky bit from the sequencer.
REQ-011 interrupt  output  1  registered single-cycle interrupt request to the core.
REQ-012 stallb_en  output  1  registered stall enable to the core (low = stall).
REQ-013 done  output  1  registered, sticky end-of-run flag.
REQ-014 done_code  output  2  registered cause: 00 none, 01 FINISH, 10 PC-stack overflow, 11 timeout.
REQ-015 tmo_cnt  output  TMO_W  current watchdog count.

Function
REQ-016 Stall generator: 4-bit phase counter plus phase bit; stallb_en high for exactly STALL_HI cycles, then low for exactly STALL_LO cycles, repeating with no gap.
REQ-017 STALL_LO=0: stallb_en constant 1.
REQ-018 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every cycle while done=0, freezes when done=1.
REQ-019 Interrupt FSM states: WAIT (ps_idle=0), COUNT (ps_idle=1, cnt>0), FIRE (one cycle, interrupt=1).
REQ-020 WAIT -> COUNT when ps_idle=1 with cnt loaded from LFSR[2:0] on entry; WAIT -> FIRE directly if loaded value is 0.
REQ-021 COUNT: cnt decrements by 1 per cycle while ps_idle=1; ps_idle=0 returns to WAIT without firing, cnt discarded.
REQ-022 COUNT -> FIRE when cnt=0 and ps_idle=1; FIRE asserts interrupt for exactly one cycle, then -> WAIT.
REQ-023 No two interrupt pulses within 2 consecutive cycles; interrupt never asserted while done=1.
REQ-024 FINISH detect: pm_ps_op[PMD_SIZE-1:PMD_SIZE-10] == 10'b0000000001.
REQ-025 Watchdog: tmo_cnt increments by 1 each cycle while done=0; timeout event when tmo_cnt = all-ones; no wrap.
REQ-026 done sets on the first cycle any of FINISH, pcstck_ovf=1, timeout is true; priority FINISH > overflow > timeout selects done_code.
REQ-027 Once done=1: done, done_code, tmo_cnt frozen; interrupt forced 0; stallb_en forced 1; FSM held in WAIT; cleared only by reset.
REQ-028 done and done_code update on the same edge; done_code is 00 whenever done=0.

Reset
REQ-029 reset low: interrupt=0, stallb_en=1, done=0, done_code=00, tmo_cnt=0, FSM=WAIT, cnt=0, stall phase=high with count 0, LFSR=LFSR_SEED (or 8'h01).
REQ-030 Reset asserted mid-count or mid-stall aborts immediately; after release, stall pattern restarts with STALL_HI high cycles and LFSR sequence restarts from seed.

Verification
REQ-031 Defaults, ps_idle=0, no events: stallb_en sequence 1,0,0,1,0,0,... from first edge after reset release; interrupt stays 0.
REQ-032 ps_idle held 1 from cycle 5: interrupt pulses exactly 1 cycle each, gap between pulses = LFSR[2:0]+2 cycles, matching a reference LFSR model from seed 8'hA5.
REQ-033 ps_idle dropped to 0 in COUNT with cnt=3: no interrupt; reasserted -> new cnt from current LFSR[2:0].
REQ-034 pm_ps_op=32'h0040_0000 and pcstck_ovf=1 on same cycle: done=1, done_code=01 next edge; interrupt=0, stallb_en=1 thereafter.
REQ-035 No events for 1023 cycles (TMO_W=10): done=1, done_code=11, tmo_cnt=10'h3FF held.
REQ-036 reset pulsed low for 2 ns mid-run after done: all outputs return to reset values asynchronously; done=0 after release.
